data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory controller with a fixed access latency.
// Optional macro DM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module data_mem_ctrl #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              write_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [7:0]        mem_q [MEM_BYTES];

  logic              accept, fire, bad, misalign;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic [3:0][AW:0]  idx;
  logic [3:0][7:0]   rbyte, wbyte;
  logic [31:0]       load_val;

  always_comb begin
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    // One extra bit so addr+bytes cannot wrap
    end_addr = {1'b0, addr_q} + (ADDR_W+1)'(nbytes);
`ifdef DM_ALIGN_CHECK_EN
    misalign = ((size_q == 2'b01) && addr_q[0]) ||
               ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    bad = (size_q == 2'b11) || (end_addr > (ADDR_W+1)'(MEM_BYTES)) || misalign;
  end

  // Byte k of the unit sits at addr+k; out-of-range lanes read as zero
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]   = {1'b0, addr_q[AW-1:0]} + (AW+1)'(k);
      rbyte[k] = (idx[k] < (AW+1)'(MEM_BYTES)) ? mem_q[idx[k][AW-1:0]] : 8'h00;
    end
  end

  always_comb begin
    wbyte = '0;
    case (size_q)
      2'b00: wbyte[0] = wdata_q[7:0];
      2'b01: begin
        wbyte[0] = wdata_q[15:8];
        wbyte[1] = wdata_q[7:0];
      end
      default: begin
        wbyte[0] = wdata_q[31:24];
        wbyte[1] = wdata_q[23:16];
        wbyte[2] = wdata_q[15:8];
        wbyte[3] = wdata_q[7:0];
      end
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & rbyte[0][7]}}, rbyte[0]};
      2'b01:   load_val = {{16{~uns_q & rbyte[0][7]}}, rbyte[0], rbyte[1]};
      default: load_val = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
    endcase
  end

  assign fire = (state_q == WAIT) && (cnt_q == 3'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        cnt_d   = 3'(LATENCY);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 3'd0) begin
        state_d = RESP;
        err_d   = bad;
        rdata_d = (bad || write_q) ? 32'h0 : load_val;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage is intentionally not reset; a reset edge suppresses a pending store
  always_ff @(posedge clk) begin
    if (!rst && fire && write_q && !bad) begin
      for (int k = 0; k < 4; k++)
        if (3'(k) < nbytes) mem_q[idx[k][AW-1:0]] <= wbyte[k];
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: random traffic against a byte-array model,
// plus a LATENCY=0 instance for back-to-back acceptance timing.
module tb_data_mem_ctrl;
  localparam int MB  = 128;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v1 = 1'b0;
  logic        rdy1, rv1, err1;
  logic [31:0] rd1;

  data_mem_ctrl #(.MEM_BYTES(MB), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  data_mem_ctrl #(.MEM_BYTES(MB), .ADDR_W(32), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1),
    .req_write(1'b1), .req_size(2'b00), .req_unsigned(1'b0),
    .req_addr(32'd3), .req_wdata(32'h000000A5), .rsp_valid(rv1),
    .rsp_rdata(rd1), .rsp_err(err1));

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] rdata; logic err; int acc;} exp_t;
  exp_t        q[$];
  exp_t        mon_e;
  logic [7:0]  mdl [MB];
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: bytes stored big-endian at consecutive addresses, range/size rules
  task automatic model(input bit w, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int nb;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (longint'(addr) + nb > MB);
`ifdef DM_ALIGN_CHECK_EN
    if ((sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0)) er = 1'b1;
`endif
    rd = '0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mdl[int'(addr) + i] = 8'(wd >> (8 * (nb - 1 - i)));
      end else begin
        for (int i = 0; i < nb; i++) rd = (rd << 8) | 32'(mdl[int'(addr) + i]);
        if (!uns && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'd1 << (8 * nb)) - 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (q.size() == 0) chk("unexpected rsp_valid", 32'd1, 32'd0);
        else begin
          mon_e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("latency", 32'(cyc - mon_e.acc), 32'(LAT + 1));
          last_rdata = mon_e.rdata;
          last_err   = mon_e.err;
        end
      end else begin
        chk("hold rdata", rsp_rdata, last_rdata);
        chk("hold err", 32'(rsp_err), 32'(last_err));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("ready timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic        er;
    wait_ready();
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    model(w, sz, uns, addr, wd, rd, er);
    q.push_back('{rd, er, cyc + 1});
    step();
    // Junk on the request fields while busy must be ignored
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom_range(0, 127); req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin step(); n++; end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("ready after reset", 32'(req_ready), 32'd1);
    chk("rsp_valid after reset", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < MB; i += 4) issue(1'b1, 2'd2, 1'b0, i, $urandom);

    issue(1'b1, 2'd2, 1'b0, 32'd8, 32'h11223344);
    issue(1'b0, 2'd0, 1'b0, 32'd9, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'd4, 32'h00000080);
    issue(1'b0, 2'd0, 1'b0, 32'd4, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'd4, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'd4, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'd126, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'd124, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 1'b1, 32'd124, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'd5, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'd6, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'd9, 32'h0000BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'd0, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'd127, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'd128, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'd127, 32'h1234);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'hFFFFFFFD, 32'h55AA55AA);

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 131);
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    drain();

    // Reset while a store is waiting: store is dropped, memory untouched
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'd40;
    req_wdata = 32'hDEADBEEF;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    last_rdata = '0;
    last_err   = 1'b0;
    rst = 1'b0;
    step();
    chk("ready after mid-wait reset", 32'(req_ready), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'd40, 32'h0);
    drain();

    // LATENCY=0 instance with valid held high: one acceptance every 3 cycles
    v1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("lat0 ready", 32'(rdy1), 32'(i % 3 == 0));
      chk("lat0 rsp_valid", 32'(rv1), 32'(i % 3 == 2));
      if (i % 3 == 2) begin
        chk("lat0 rdata", rd1, 32'h0);
        chk("lat0 err", 32'(err1), 32'd0);
      end
      step();
    end
    v1 = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
